// File: rtl/masking_pkg.sv
// Shared parameters and helpers for masked arithmetic datapaths.
// Share i of a masked word lives at [share_lo(i, K) +: K].
package masking_pkg;
  localparam int K_WIDTH_DEF  = 32;
  localparam int N_SHARES_DEF = 8;

  function automatic int mask_width(input int k, input int n);
    return k * n;
  endfunction

  // Arithmetic refresh needs one fresh word per share except the last.
  function automatic int rand_num(input int n);
    return n - 1;
  endfunction

  function automatic int share_lo(input int i, input int k);
    return i * k;
  endfunction
endpackage

// File: rtl/sec_arith_refresh.sv
// Combinational arithmetic refresh of N shares with N-1 fresh words.
// Adds r[i] to shares 0..N-2 and subtracts their sum from share N-1.
module sec_arith_refresh
  import masking_pkg::*;
#(
  parameter int K_WIDTH  = K_WIDTH_DEF,
  parameter int N_SHARES = N_SHARES_DEF,
  localparam int MASKWIDTH = mask_width(K_WIDTH, N_SHARES),
  localparam int RANDNUM   = rand_num(N_SHARES)
) (
  input  logic [MASKWIDTH-1:0]       i_a,
  input  logic [K_WIDTH*RANDNUM-1:0] rnd,
  output logic [MASKWIDTH-1:0]       o_a
);

  localparam int LAST = N_SHARES - 1;

  logic [K_WIDTH-1:0] rsum;

  always_comb begin
    rsum = '0;
    o_a  = '0;
    for (int i = 0; i < LAST; i++) begin
      o_a[share_lo(i, K_WIDTH) +: K_WIDTH] =
        i_a[share_lo(i, K_WIDTH) +: K_WIDTH]
        + rnd[share_lo(i, K_WIDTH) +: K_WIDTH];
      rsum = rsum + rnd[share_lo(i, K_WIDTH) +: K_WIDTH];
    end
    o_a[share_lo(LAST, K_WIDTH) +: K_WIDTH] =
      i_a[share_lo(LAST, K_WIDTH) +: K_WIDTH] - rsum;
  end

endmodule

// File: rtl/sec_arith_acc.sv
// Share-wise masked accumulator over ACC_LEN samples with refreshed,
// valid/ready-registered result and sticky overwrite flag.
module sec_arith_acc
  import masking_pkg::*;
#(
  parameter int K_WIDTH  = K_WIDTH_DEF,
  parameter int N_SHARES = N_SHARES_DEF,
  parameter int ACC_LEN  = 16,
  localparam int MASKWIDTH = mask_width(K_WIDTH, N_SHARES),
  localparam int CNT_W     = $clog2(ACC_LEN + 1),
  localparam int RANDNUM   = rand_num(N_SHARES)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ena,
  input  logic                       clr,
  input  logic                       i_vld,
  input  logic [MASKWIDTH-1:0]       i_a,
  input  logic [K_WIDTH*RANDNUM-1:0] rnd,
  input  logic                       o_rdy,
  output logic [MASKWIDTH-1:0]       o_a,
  output logic                       o_vld,
  output logic [CNT_W-1:0]           o_cnt,
  output logic                       o_ovf
);

  logic [MASKWIDTH-1:0] acc_q, acc_d;
  logic [MASKWIDTH-1:0] o_a_q, o_a_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 o_vld_q, o_vld_d;
  logic                 o_ovf_q, o_ovf_d;

  logic [MASKWIDTH-1:0] sum_w;
  logic [MASKWIDTH-1:0] fresh_w;
  logic                 accept;
  logic                 last;

  assign accept = i_vld && ena && !clr;
  assign last   = (cnt_q == CNT_W'(ACC_LEN - 1));

  // Share-wise add only; shares are never combined here.
  always_comb begin
    sum_w = '0;
    for (int i = 0; i < N_SHARES; i++) begin
      sum_w[share_lo(i, K_WIDTH) +: K_WIDTH] =
        acc_q[share_lo(i, K_WIDTH) +: K_WIDTH]
        + i_a[share_lo(i, K_WIDTH) +: K_WIDTH];
    end
  end

  sec_arith_refresh #(
    .K_WIDTH  (K_WIDTH),
    .N_SHARES (N_SHARES)
  ) u_refresh (
    .i_a (sum_w),
    .rnd (rnd),
    .o_a (fresh_w)
  );

  always_comb begin
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    o_a_d   = o_a_q;
    o_vld_d = o_vld_q;
    o_ovf_d = o_ovf_q;
    if (clr) begin
      acc_d   = '0;
      cnt_d   = '0;
      o_vld_d = 1'b0;
      o_ovf_d = 1'b0;
    end else begin
      if (o_vld_q && o_rdy) begin
        o_vld_d = 1'b0;
      end
      if (accept) begin
        if (last) begin
          o_a_d   = fresh_w;
          o_vld_d = 1'b1;
          acc_d   = '0;
          cnt_d   = '0;
          if (o_vld_q && !o_rdy) begin
            o_ovf_d = 1'b1;
          end
        end else begin
          acc_d = sum_w;
          cnt_d = cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      o_a_q   <= '0;
      o_vld_q <= 1'b0;
      o_ovf_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      o_a_q   <= o_a_d;
      o_vld_q <= o_vld_d;
      o_ovf_q <= o_ovf_d;
    end
  end

  assign o_a   = o_a_q;
  assign o_vld = o_vld_q;
  assign o_cnt = cnt_q;
  assign o_ovf = o_ovf_q;

endmodule

// File: tb/tb_sec_arith_acc.sv
// Directed bench for sec_arith_acc with K=32, N=8, ACC_LEN=4.
// Inputs change on the falling edge; outputs are checked there too.
module tb_sec_arith_acc;

  localparam int K  = 32;
  localparam int N  = 8;
  localparam int L  = 4;
  localparam int MW = K * N;
  localparam int RW = K * (N - 1);
  localparam int CW = $clog2(L + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ena = 1'b1;
  logic          clr = 1'b0;
  logic          i_vld = 1'b0;
  logic [MW-1:0] i_a = '0;
  logic [RW-1:0] rnd = '0;
  logic          o_rdy = 1'b1;
  logic [MW-1:0] o_a;
  logic          o_vld;
  logic [CW-1:0] o_cnt;
  logic          o_ovf;

  sec_arith_acc #(
    .K_WIDTH  (K),
    .N_SHARES (N),
    .ACC_LEN  (L)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .clr   (clr),
    .i_vld (i_vld),
    .i_a   (i_a),
    .rnd   (rnd),
    .o_rdy (o_rdy),
    .o_a   (o_a),
    .o_vld (o_vld),
    .o_cnt (o_cnt),
    .o_ovf (o_ovf)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  typedef logic [L-1:0][MW-1:0] blk_sh_t;
  typedef logic [L-1:0][RW-1:0] blk_rn_t;

  typedef struct packed {
    logic [L-1:0][K-1:0] s;
    logic [K-1:0]        sum;
  } vec_t;

  task automatic chk(input string nm, input logic [MW-1:0] act,
                     input logic [MW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [MW-1:0] mk_shares(input logic [K-1:0] s);
    logic [MW-1:0] v;
    logic [K-1:0]  t;
    v = '0;
    t = '0;
    for (int i = 0; i < N - 1; i++) begin
      v[i*K +: K] = $urandom;
      t = t + v[i*K +: K];
    end
    v[(N-1)*K +: K] = s - t;
    return v;
  endfunction

  function automatic logic [K-1:0] ssum(input logic [MW-1:0] a);
    logic [K-1:0] t;
    t = '0;
    for (int i = 0; i < N; i++) t = t + a[i*K +: K];
    return t;
  endfunction

  function automatic logic [RW-1:0] mk_rnd();
    logic [RW-1:0] r;
    for (int i = 0; i < N - 1; i++) r[i*K +: K] = $urandom | 32'h1;
    return r;
  endfunction

  function automatic blk_sh_t mk_block(input logic [L-1:0][K-1:0] s);
    blk_sh_t b;
    for (int j = 0; j < L; j++) b[j] = mk_shares(s[j]);
    return b;
  endfunction

  function automatic blk_rn_t mk_rblk(input bit zero);
    blk_rn_t b;
    for (int j = 0; j < L; j++) b[j] = zero ? '0 : mk_rnd();
    return b;
  endfunction

  task automatic drive(input logic [MW-1:0] sh, input logic [RW-1:0] r);
    @(negedge clk);
    i_vld = 1'b1;
    i_a   = sh;
    rnd   = r;
  endtask

  task automatic idle();
    @(negedge clk);
    i_vld = 1'b0;
    rnd   = mk_rnd();
  endtask

  // Feeds one block; returns the independently modelled refreshed result.
  task automatic run_block(input blk_sh_t sh, input blk_rn_t r,
                           input logic rdy_last,
                           output logic [MW-1:0] exp);
    logic [MW-1:0] acc;
    logic [K-1:0]  rs;
    acc = '0;
    for (int j = 0; j < L; j++) begin
      for (int i = 0; i < N; i++)
        acc[i*K +: K] = acc[i*K +: K] + sh[j][i*K +: K];
      drive(sh[j], r[j]);
      if (j == L - 1) o_rdy = rdy_last;
    end
    rs = '0;
    for (int i = 0; i < N - 1; i++) begin
      exp[i*K +: K] = acc[i*K +: K] + r[L-1][i*K +: K];
      rs = rs + r[L-1][i*K +: K];
    end
    exp[(N-1)*K +: K] = acc[(N-1)*K +: K] - rs;
    idle();
  endtask

  vec_t          vecs [5];
  logic [MW-1:0] e, e2, saved;
  blk_sh_t       bs;

  initial begin
    vecs[0] = '{s: {32'd4, 32'd3, 32'd2, 32'd1}, sum: 32'd10};
    vecs[1] = '{s: {4{32'hFFFF_FFFF}}, sum: 32'hFFFF_FFFC};
    vecs[2] = '{s: {32'd0, 32'd0, 32'd0, 32'd0}, sum: 32'd0};
    vecs[3] = '{s: {32'd7, 32'd5, 32'h8000_0000, 32'h8000_0000},
                sum: 32'd12};
    vecs[4] = '{s: {32'h1234_5678, 32'h0, 32'h1111_1111, 32'hDEAD_BEEF},
                sum: 32'h1234_5678 + 32'h1111_1111 + 32'hDEAD_BEEF};

    repeat (2) @(negedge clk);
    chk("rst_o_a", o_a, '0);
    chk("rst_o_vld", MW'(o_vld), '0);
    chk("rst_o_cnt", MW'(o_cnt), '0);
    chk("rst_o_ovf", MW'(o_ovf), '0);
    rst_n = 1'b1;

    for (int v = 0; v < 5; v++) begin
      run_block(mk_block(vecs[v].s), mk_rblk(0), 1'b1, e);
      chk($sformatf("v%0d_vld", v), MW'(o_vld), MW'(1));
      chk($sformatf("v%0d_cnt", v), MW'(o_cnt), '0);
      chk($sformatf("v%0d_sum", v), MW'(ssum(o_a)), MW'(vecs[v].sum));
      chk($sformatf("v%0d_o_a", v), o_a, e);
      @(negedge clk);
      chk($sformatf("v%0d_drop", v), MW'(o_vld), '0);
    end

    // ena low between samples 2 and 3 while i_vld stays high
    drive(mk_shares(32'd5), mk_rnd());
    drive(mk_shares(32'd6), mk_rnd());
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("ena_hold%0d", c), MW'(o_cnt), MW'(2));
      ena   = 1'b0;
      i_vld = 1'b1;
      i_a   = mk_shares(32'd100);
    end
    @(negedge clk);
    chk("ena_hold3", MW'(o_cnt), MW'(2));
    ena = 1'b1;
    i_a = mk_shares(32'd7);
    drive(mk_shares(32'd8), mk_rnd());
    idle();
    chk("ena_vld", MW'(o_vld), MW'(1));
    chk("ena_sum", MW'(ssum(o_a)), MW'(26));
    @(negedge clk);

    // overwrite with o_rdy low
    o_rdy = 1'b0;
    run_block(mk_block({4{32'd1}}), mk_rblk(0), 1'b0, e);
    chk("ow_a_vld", MW'(o_vld), MW'(1));
    chk("ow_a_ovf", MW'(o_ovf), '0);
    run_block(mk_block({4{32'd2}}), mk_rblk(0), 1'b0, e);
    chk("ow_b_ovf", MW'(o_ovf), MW'(1));
    chk("ow_b_sum", MW'(ssum(o_a)), MW'(8));
    chk("ow_b_o_a", o_a, e);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr_ovf", MW'(o_ovf), '0);
    chk("clr_vld", MW'(o_vld), '0);

    // completion coinciding with consume
    run_block(mk_block({4{32'd3}}), mk_rblk(0), 1'b0, e);
    chk("col_c_vld", MW'(o_vld), MW'(1));
    run_block(mk_block({4{32'd9}}), mk_rblk(0), 1'b1, e);
    chk("col_ovf", MW'(o_ovf), '0);
    chk("col_vld", MW'(o_vld), MW'(1));
    chk("col_o_a", o_a, e);
    chk("col_sum", MW'(ssum(o_a)), MW'(36));
    @(negedge clk);
    chk("col_drop", MW'(o_vld), '0);

    // clr at o_cnt=3, with a sample offered in the same cycle
    for (int j = 0; j < 3; j++) drive(mk_shares(32'd1), mk_rnd());
    @(negedge clk);
    chk("clr3_cnt_pre", MW'(o_cnt), MW'(3));
    clr = 1'b1;
    i_a = mk_shares(32'd1);
    @(negedge clk);
    clr   = 1'b0;
    i_vld = 1'b0;
    chk("clr3_cnt", MW'(o_cnt), '0);
    chk("clr3_vld", MW'(o_vld), '0);

    // clr in the completion cycle
    for (int j = 0; j < 3; j++) drive(mk_shares(32'd1), mk_rnd());
    drive(mk_shares(32'd1), mk_rnd());
    clr = 1'b1;
    @(negedge clk);
    clr   = 1'b0;
    i_vld = 1'b0;
    chk("clrc_vld", MW'(o_vld), '0);
    chk("clrc_cnt", MW'(o_cnt), '0);
    repeat (2) @(negedge clk);
    chk("clrc_quiet", MW'(o_vld), '0);

    // fresh block after clr starts at sample 0; leave result pending
    o_rdy = 1'b0;
    run_block(mk_block(vecs[0].s), mk_rblk(0), 1'b0, e);
    chk("post_clr_sum", MW'(ssum(o_a)), MW'(10));

    // asynchronous reset mid-block
    drive(mk_shares(32'd50), mk_rnd());
    drive(mk_shares(32'd60), mk_rnd());
    @(negedge clk);
    i_vld = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_o_a", o_a, '0);
    chk("arst_vld", MW'(o_vld), '0);
    chk("arst_cnt", MW'(o_cnt), '0);
    chk("arst_ovf", MW'(o_ovf), '0);
    @(negedge clk);
    rst_n = 1'b1;
    o_rdy = 1'b1;
    run_block(mk_block(vecs[0].s), mk_rblk(0), 1'b1, e);
    chk("arst_next_sum", MW'(ssum(o_a)), MW'(10));
    @(negedge clk);

    // same shares, zero versus random refresh
    bs = mk_block(vecs[4].s);
    run_block(bs, mk_rblk(1), 1'b1, e);
    chk("rz_o_a", o_a, e);
    saved = o_a;
    @(negedge clk);
    run_block(bs, mk_rblk(0), 1'b1, e2);
    chk("rr_o_a", o_a, e2);
    chk("rr_sum", MW'(ssum(o_a)), MW'(ssum(saved)));
    chk("rr_differs", MW'(o_a != saved), MW'(1));
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
